ldl_round_dispatch: RTL and testbench

Round-robin stream distributor, the opposite end of the round-robin arbiter. The arbiter merges N requesters into one grant. This block takes a single valid/ready input stream and deals each accepted beat to one of CH_NUM output lanes in rotating order. Each lane has a 1-entry holding register. Stalled lanes are skipped, so one slow consumer cannot block the others. It sits in front of parallel worker engines.

---
 rtl/ldl_round_dispatch.sv | 91 +++++++++
 tb/tb_ldl_round_dispatch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_round_dispatch.sv
// Round-robin stream distributor: deals each accepted upstream beat to the next free
// output lane, starting the search at a rotating pointer. Each lane holds one beat.
module ldl_round_dispatch #(
   parameter int unsigned BIN_WIDTH  = 3,
   parameter int unsigned CH_NUM     = 1 << BIN_WIDTH,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   output logic [CH_NUM-1:0]            m_valid,
   input  logic [CH_NUM-1:0]            m_ready,
   output logic [CH_NUM*DATA_WIDTH-1:0] m_data,
   output logic [BIN_WIDTH-1:0]         last_bin,
   output logic [CH_NUM-1:0]            last_hot
);

   logic [CH_NUM-1:0]                 vld_q, vld_d;
   logic [CH_NUM-1:0][DATA_WIDTH-1:0] dat_q, dat_d;
   logic [BIN_WIDTH-1:0]              next_q, next_d;
   logic [BIN_WIDTH-1:0]              last_bin_q, last_bin_d;
   logic [CH_NUM-1:0]                 last_hot_q, last_hot_d;
   logic [CH_NUM-1:0]                 free;
   logic [CH_NUM-1:0]                 rot;
   logic [BIN_WIDTH-1:0]              off;
   logic [BIN_WIDTH-1:0]              sel;
   logic                              accept;

   // A lane draining this cycle counts as free so it can be reloaded in the same cycle.
   assign free    = ~vld_q | m_ready;
   assign s_ready = |free;
   assign accept  = s_valid & s_ready;

   // Rotate so bit 0 is the lane at the pointer; lowest set bit is the first free lane.
   always_comb begin
      rot = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         rot[i] = free[BIN_WIDTH'(i) + next_q];
      end
   end

   always_comb begin
      off = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = BIN_WIDTH'(i);
         end
      end
   end

   assign sel = off + next_q;

   always_comb begin
      vld_d      = vld_q & ~m_ready;
      dat_d      = dat_q;
      next_d     = next_q;
      last_bin_d = last_bin_q;
      last_hot_d = last_hot_q;
      if (accept) begin
         vld_d[sel] = 1'b1;
         dat_d[sel] = s_data;
         next_d     = sel + BIN_WIDTH'(1);
         last_bin_d = sel;
         last_hot_d = {{(CH_NUM - 1){1'b0}}, 1'b1} << sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         dat_q      <= '0;
         next_q     <= '0;
         last_bin_q <= '0;
         last_hot_q <= '0;
      end else begin
         vld_q      <= vld_d;
         dat_q      <= dat_d;
         next_q     <= next_d;
         last_bin_q <= last_bin_d;
         last_hot_q <= last_hot_d;
      end
   end

   assign m_valid  = vld_q;
   assign m_data   = dat_q;
   assign last_bin = last_bin_q;
   assign last_hot = last_hot_q;

endmodule

// File: tb/tb_ldl_round_dispatch.sv
// Bench for ldl_round_dispatch: directed scenarios plus a reference model whose accepted
// beats are queued per lane and compared when the lane is drained.
module tb_ldl_round_dispatch;

   localparam int CH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic [7:0]  m_valid;
   logic [7:0]  m_ready;
   logic [63:0] m_data;
   logic [2:0]  last_bin;
   logic [7:0]  last_hot;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] lane;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mvld  = '0;
   int         mnext = 0;
   logic [2:0] mlast = '0;
   logic [7:0] mhot  = '0;
   bit         mon_en = 1'b0;
   logic [7:0] m_free;
   logic       m_acc;
   int         m_lane;

   ldl_round_dispatch #(
      .BIN_WIDTH (3),
      .CH_NUM    (8),
      .DATA_WIDTH(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .last_bin(last_bin),
      .last_hot(last_hot)
   );

   always #5 clk = ~clk;

   // Search order next, next+1, ... wrapping; first free lane wins.
   function automatic int pick(input logic [7:0] fr, input int nxt);
      int idx;
      for (int k = 0; k < CH; k++) begin
         idx = (nxt + k) % CH;
         if (fr[idx]) return idx;
      end
      return -1;
   endfunction

   always_comb begin
      m_free = ~mvld | m_ready;
      m_acc  = s_valid && (m_free != 8'h00);
      m_lane = pick(m_free, mnext);
   end

   always @(posedge clk) begin
      if (rst) begin
         mvld   <= '0;
         mnext  <= 0;
         mlast  <= '0;
         mhot   <= '0;
         mon_en <= 1'b1;
         sb.delete();
      end else begin
         mvld <= (mvld & ~m_ready) | (m_acc ? (8'h01 << m_lane) : 8'h00);
         if (m_acc) begin
            sb.push_back({3'(m_lane), s_data});
            mnext <= (m_lane + 1) % CH;
            mlast <= 3'(m_lane);
            mhot  <= 8'h01 << m_lane;
         end
      end
   end

   always @(negedge clk) begin
      int found;
      if (mon_en && !rst) begin
         checks++;
         if (m_valid !== mvld) begin
            errors++;
            $display("FAIL mon_m_valid t=%0t: got %h expected %h", $time, m_valid, mvld);
         end
         checks++;
         if (s_ready !== (m_free != 8'h00)) begin
            errors++;
            $display("FAIL mon_s_ready t=%0t: got %b expected %b", $time, s_ready, m_free != 0);
         end
         checks++;
         if (last_bin !== mlast || last_hot !== mhot) begin
            errors++;
            $display("FAIL mon_last t=%0t: got bin %0d hot %h expected bin %0d hot %h",
                     $time, last_bin, last_hot, mlast, mhot);
         end
         for (int i = 0; i < CH; i++) begin
            if (mvld[i] && m_ready[i]) begin
               found = -1;
               for (int j = 0; j < sb.size(); j++) begin
                  if (sb[j].lane == 3'(i) && found < 0) found = j;
               end
               checks++;
               if (found < 0) begin
                  errors++;
                  $display("FAIL mon_drain lane %0d: got %h expected a queued beat", i,
                           m_data[i*8 +: 8]);
               end else begin
                  if (m_data[i*8 +: 8] !== sb[found].data) begin
                     errors++;
                     $display("FAIL mon_drain lane %0d: got %h expected %h", i,
                              m_data[i*8 +: 8], sb[found].data);
                  end
                  sb.delete(found);
               end
            end
         end
      end
   end

   task automatic do_reset(input int n);
      rst     = 1'b1;
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Presents one beat and holds it until accepted; returns just after the accepting edge.
   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (s_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got s_ready %b expected 1", s_ready);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      m_ready = 8'h00;
      do_reset(2);
      @(negedge clk);
      checks++;
      if (m_valid !== 8'h00 || s_ready !== 1'b1 || last_hot !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got m_valid %h s_ready %b last_hot %h expected 00 1 00",
                  m_valid, s_ready, last_hot);
      end
      send(8'hA5);
      @(negedge clk);
      checks++;
      if (m_valid !== 8'h01 || m_data[7:0] !== 8'hA5) begin
         errors++;
         $display("FAIL reset_first_beat: got m_valid %h lane0 %h expected 01 a5",
                  m_valid, m_data[7:0]);
      end
   endtask

   task automatic test_streaming();
      do_reset(1);
      m_ready = 8'hFF;
      s_valid = 1'b1;
      s_data  = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (m_valid !== (8'h01 << ((i - 1) % CH)) ||
                m_data[((i - 1) % CH)*8 +: 8] !== 8'(i - 1)) begin
               errors++;
               $display("FAIL stream_beat %0d: got m_valid %h data %h expected %h %h", i - 1,
                        m_valid, m_data[((i - 1) % CH)*8 +: 8], 8'h01 << ((i - 1) % CH),
                        8'(i - 1));
            end
         end
         checks++;
         if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_s_ready %0d: got %b expected 1", i, s_ready);
         end
         @(posedge clk);
         #1;
         if (i < 9) s_data = 8'(i + 1);
         else s_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 8'h02 || m_data[15:8] !== 8'h09 || last_bin !== 3'd1) begin
         errors++;
         $display("FAIL stream_final: got m_valid %h lane1 %h last_bin %0d expected 02 09 1",
                  m_valid, m_data[15:8], last_bin);
      end
      send(8'h0A);
      @(negedge clk);
      checks++;
      if (last_bin !== 3'd2) begin
         errors++;
         $display("FAIL stream_next_ptr: got last_bin %0d expected 2", last_bin);
      end
   endtask

   task automatic test_fill_backpressure();
      do_reset(1);
      m_ready = 8'h00;
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
      @(negedge clk);
      checks++;
      if (m_valid !== 8'hFF) begin
         errors++;
         $display("FAIL fill_full: got m_valid %h expected ff", m_valid);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = 8'h18;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_stall: got s_ready %b expected 0", s_ready);
      end
      @(posedge clk);
      #1;
      m_ready = 8'h08;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_pulse_ready: got s_ready %b expected 1", s_ready);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      m_ready = 8'h00;
      @(negedge clk);
      checks++;
      if (m_valid !== 8'hFF || m_data[31:24] !== 8'h18 || last_bin !== 3'd3) begin
         errors++;
         $display("FAIL fill_reload: got m_valid %h lane3 %h last_bin %0d expected ff 18 3",
                  m_valid, m_data[31:24], last_bin);
      end
      // Lanes 2 and 4 free: a pointer at 4 must pick lane 4, not lane 2.
      m_ready = 8'h14;
      send(8'h19);
      m_ready = 8'h00;
      @(negedge clk);
      checks++;
      if (last_bin !== 3'd4 || m_valid !== 8'hFB) begin
         errors++;
         $display("FAIL fill_next_ptr: got last_bin %0d m_valid %h expected 4 fb",
                  last_bin, m_valid);
      end
   endtask

   task automatic test_skip_stalled();
      do_reset(1);
      m_ready = 8'h00;
      for (int i = 0; i < 8; i++) send(8'(8'h20 + i));
      m_ready = 8'h01;
      send(8'h28);
      m_ready = 8'hF9;
      @(posedge clk);
      #1;
      m_ready = 8'h00;
      @(negedge clk);
      checks++;
      if (m_valid !== 8'h06 || last_bin !== 3'd0) begin
         errors++;
         $display("FAIL skip_setup: got m_valid %h last_bin %0d expected 06 0",
                  m_valid, last_bin);
      end
      send(8'h29);
      @(negedge clk);
      checks++;
      if (last_hot !== 8'h08 || last_bin !== 3'd3 || m_valid !== 8'h0E) begin
         errors++;
         $display("FAIL skip_lane3: got last_hot %h last_bin %0d m_valid %h expected 08 3 0e",
                  last_hot, last_bin, m_valid);
      end
   endtask

   task automatic test_idle_gaps();
      m_ready = 8'h00;
      s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (last_bin !== 3'd3 || last_hot !== 8'h08) begin
            errors++;
            $display("FAIL idle_hold %0d: got last_bin %0d last_hot %h expected 3 08",
                     i, last_bin, last_hot);
         end
      end
      send(8'h2A);
      @(negedge clk);
      checks++;
      if (last_bin !== 3'd4 || m_valid !== 8'h1E) begin
         errors++;
         $display("FAIL idle_next_ptr: got last_bin %0d m_valid %h expected 4 1e",
                  last_bin, m_valid);
      end
   endtask

   task automatic test_reset_mid();
      m_ready = 8'h00;
      for (int i = 0; i < 4; i++) send(8'(8'h2B + i));
      @(negedge clk);
      checks++;
      if (m_valid !== 8'hFF) begin
         errors++;
         $display("FAIL mid_full: got m_valid %h expected ff", m_valid);
      end
      do_reset(1);
      @(negedge clk);
      checks++;
      if (m_valid !== 8'h00 || last_hot !== 8'h00 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got m_valid %h last_hot %h s_ready %b expected 00 00 1",
                  m_valid, last_hot, s_ready);
      end
      send(8'h30);
      @(negedge clk);
      checks++;
      if (last_bin !== 3'd0 || m_valid !== 8'h01 || m_data[7:0] !== 8'h30) begin
         errors++;
         $display("FAIL mid_first_beat: got last_bin %0d m_valid %h lane0 %h expected 0 01 30",
                  last_bin, m_valid, m_data[7:0]);
      end
   endtask

   task automatic test_random();
      bit acc;
      do_reset(1);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (!s_valid || acc) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
         end
         m_ready = 8'($urandom) & 8'($urandom);
      end
      @(posedge clk);
      #1;
      m_ready = 8'hFF;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (sb.size() != 0 || m_valid !== 8'h00) begin
         errors++;
         $display("FAIL random_drain: got %0d queued, m_valid %h expected 0 00",
                  sb.size(), m_valid);
      end
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = 8'h00;
      m_ready = 8'h00;
      test_reset();
      test_streaming();
      test_fill_backpressure();
      test_skip_stalled();
      test_idle_gaps();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
